// File: rtl/pdm_microphone_receiver.sv
// PDM microphone front end: mic clock generation, 1-bit capture, 3rd-order CIC
// decimator to 16-bit PCM and a first-word-fall-through sample FIFO.
module pdm_microphone_receiver #(
  parameter int CLK_DIVIDER = 50,
  parameter int DECIMATION  = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        pdm_data_i,
  output logic        pdm_clk_o,
  output logic        pdm_lrsel_o,
  output logic [15:0] pcm_data_o,
  output logic        pcm_valid_o,
  input  logic        pcm_read_i,
  output logic        fifo_full_o,
  output logic        overrun_o,
  input  logic        clear_overrun_i
);
  localparam int DW   = 19;
  localparam int DIVW = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;
  localparam int DECW = $clog2(DECIMATION);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIVIDER - 1);
  localparam logic [DECW-1:0] DEC_LAST  = DECW'(DECIMATION - 1);
  localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);

  typedef logic signed [DW-1:0] acc_t;

  // ---------------- mic clock ----------------
  logic [DIVW-1:0] div_q, div_d;
  logic            pclk_q, pclk_d;
  logic            strobe;

  always_comb begin
    div_d  = div_q;
    pclk_d = pclk_q;
    if (!enable_i) begin
      div_d  = '0;
      pclk_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      pclk_d = ~pclk_q;
    end else begin
      div_d  = div_q + DIVW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pclk_q <= pclk_d;
    end
  end

  assign strobe = enable_i & pclk_q & (div_q == DIV_LAST);

  // ---------------- CIC datapath ----------------
  logic [1:0]      sync_q;
  acc_t            x, i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [DECW-1:0] dec_q;
  acc_t            cap_q, cap_prev_q, c1_prev_q, c2_prev_q, comb_q, c1, c2, c3;
  logic            cap_bit_q, comb_bit_q;
  logic [1:0]      vld_pipe_q;
  logic [1:0]      warm_q;
  logic            capture, push;

  always_comb begin
    x    = sync_q[1] ? 19'sd1 : -19'sd1;
    i1_d = i1_q + x;
    i2_d = i2_q + i1_d;
    i3_d = i3_q + i2_d;
    c1   = cap_q - cap_prev_q;
    c2   = c1 - c1_prev_q;
    c3   = c2 - c2_prev_q;
  end

  assign capture = strobe & (dec_q == DEC_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0; i1_q <= '0; i2_q <= '0; i3_q <= '0; dec_q <= '0;
      cap_q <= '0; cap_prev_q <= '0; c1_prev_q <= '0; c2_prev_q <= '0; comb_q <= '0;
      cap_bit_q <= 1'b0; comb_bit_q <= 1'b0; vld_pipe_q <= '0; warm_q <= '0;
    end else if (!enable_i) begin
      sync_q <= '0; i1_q <= '0; i2_q <= '0; i3_q <= '0; dec_q <= '0;
      cap_q <= '0; cap_prev_q <= '0; c1_prev_q <= '0; c2_prev_q <= '0; comb_q <= '0;
      cap_bit_q <= 1'b0; comb_bit_q <= 1'b0; vld_pipe_q <= '0; warm_q <= '0;
    end else begin
      sync_q     <= {sync_q[0], pdm_data_i};
      vld_pipe_q <= {vld_pipe_q[0], capture};
      if (strobe) begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        i3_q  <= i3_d;
        dec_q <= dec_q + DECW'(1);
      end
      if (capture) begin
        cap_q     <= i3_d;
        cap_bit_q <= sync_q[1];
      end
      if (vld_pipe_q[0]) begin
        cap_prev_q <= cap_q;
        c1_prev_q  <= c1;
        c2_prev_q  <= c2;
        comb_q     <= c3;
        comb_bit_q <= cap_bit_q;
      end
      if (vld_pipe_q[1] && warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // +2^18 and -2^18 alias to the same 19-bit pattern; only an all-equal window
  // reaches either, so the newest bit of the window tells them apart.
  logic signed [DW:0] wide, shr;
  logic [15:0]        pcm_s;

  always_comb begin
    wide = {comb_q[DW-1], comb_q};
    if (comb_q == 19'h40000) wide = comb_bit_q ? 20'sh40000 : -20'sh40000;
    shr = wide >>> 3;
    if (shr > 20'sd32767)       pcm_s = 16'h7fff;
    else if (shr < -20'sd32768) pcm_s = 16'h8000;
    else                        pcm_s = shr[15:0];
  end

  assign push = vld_pipe_q[1] & (warm_q == 2'd3) & enable_i;

  // ---------------- FWFT FIFO ----------------
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          empty, full, pop, wr_en, drop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FIFO_FULL);
  assign pop   = pcm_read_i & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
    ovr_d = ovr_q;
    if (clear_overrun_i) ovr_d = 1'b0;
    if (drop)            ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= pcm_s;
  end

  assign pdm_clk_o   = pclk_q;
  assign pdm_lrsel_o = 1'b0;
  assign pcm_valid_o = ~empty;
  assign pcm_data_o  = empty ? 16'h0000 : mem_q[rd_q];
  assign fifo_full_o = full;
  assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_pdm_microphone_receiver.sv
// Bench for pdm_microphone_receiver: directed scenarios plus a convolution-based
// reference of the decimator and a queue model of the sample FIFO.
module tb_pdm_microphone_receiver;
  localparam int DIV   = 5;
  localparam int R     = 64;
  localparam int DEPTH = 16;
  localparam int NH    = 3*R - 2;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pdm_data = 1'b0;
  logic pcm_read = 1'b0, clr = 1'b0;
  logic pdm_clk_o, pdm_lrsel_o, pcm_valid_o, fifo_full_o, overrun_o;
  logic [15:0] pcm_data_o;

  pdm_microphone_receiver #(.CLK_DIVIDER(DIV), .DECIMATION(R), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pdm_data_i(pdm_data),
    .pdm_clk_o(pdm_clk_o), .pdm_lrsel_o(pdm_lrsel_o), .pcm_data_o(pcm_data_o),
    .pcm_valid_o(pcm_valid_o), .pcm_read_i(pcm_read), .fifo_full_o(fifo_full_o),
    .overrun_o(overrun_o), .clear_overrun_i(clr)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Impulse response of three cascaded length-R boxcars.
  int h[NH];
  initial begin
    for (int k = 0; k < NH; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a+b+c]++;
  end

  function automatic int to_pcm(input int y);
    int s;
    s = y >>> 3;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  int hist[$], due_q[$], val_q[$], fq[$];
  int nbits = 0, ndec = 0, ecnt = 0, m_v, y;
  bit ov = 1'b0;
  bit m_r, m_en, m_rd, m_cl, m_b, m_pco, m_pcn, m_pop, m_push, m_full;

  always @(posedge clk) begin
    m_r = rst_n; m_en = enable; m_rd = pcm_read; m_cl = clr; m_b = pdm_data; m_pco = pdm_clk_o;
    #1;
    m_pcn = pdm_clk_o;
    ecnt++;
    if (!m_r) begin
      hist.delete(); due_q.delete(); val_q.delete(); fq.delete();
      nbits = 0; ndec = 0; ov = 1'b0;
    end else begin
      m_pop  = m_rd && (fq.size() > 0);
      m_push = m_en && (due_q.size() > 0) && (due_q[0] == ecnt);
      m_v = 0;
      if (m_push) begin
        m_v = val_q.pop_front();
        void'(due_q.pop_front());
      end
      if (!m_en) begin
        hist.delete(); due_q.delete(); val_q.delete(); nbits = 0; ndec = 0;
      end
      m_full = (fq.size() == DEPTH);
      if (m_pop) void'(fq.pop_front());
      if (m_cl) ov = 1'b0;
      if (m_push) begin
        if (m_full && !m_pop) ov = 1'b1;
        else fq.push_back(m_v);
      end
      if (m_en && m_pco && !m_pcn) begin
        hist.push_back(m_b ? 1 : -1);
        if (hist.size() > NH) void'(hist.pop_front());
        nbits++;
        if (nbits % R == 0) begin
          ndec++;
          if (ndec > 3) begin
            y = 0;
            for (int k = 0; k < NH && k < hist.size(); k++) y += h[k] * hist[hist.size()-1-k];
            due_q.push_back(ecnt + 2);
            val_q.push_back(to_pcm(y));
          end
        end
      end
    end
  end

  // Every-cycle comparison of the FIFO-side outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", int'(pcm_valid_o), 0);
      chk("rst_data", int'(pcm_data_o), 0);
      chk("rst_full", int'(fifo_full_o), 0);
      chk("rst_overrun", int'(overrun_o), 0);
      chk("rst_pdm_clk", int'(pdm_clk_o), 0);
    end else begin
      chk("valid", int'(pcm_valid_o), (fq.size() > 0) ? 1 : 0);
      if (fq.size() > 0) chk("data", int'($signed(pcm_data_o)), fq[0]);
      chk("full", int'(fifo_full_o), (fq.size() == DEPTH) ? 1 : 0);
      chk("overrun", int'(overrun_o), int'(ov));
    end
    chk("lrsel", int'(pdm_lrsel_o), 0);
  end

  // ---------------- stimulus ----------------
  logic [3:0] pat = 4'b1111;
  int pidx = 0;

  initial forever begin
    @(posedge pdm_clk_o);
    #1;
    pdm_data = pat[pidx];
    pidx = (pidx + 1) % 4;
  end

  task automatic set_pat(input logic [3:0] p);
    pat = p;
    pidx = 0;
    pdm_data = p[0];
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return pcm_valid_o;
      1: return fifo_full_o;
      2: return overrun_o;
      default: return pdm_clk_o;
    endcase
  endfunction

  task automatic wait_until(input string nm, input int sel, input int budget);
    int n;
    n = 0;
    while (!sig(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) begin
      nvec++; nmis++;
      $display("FAIL %s: timeout after %0d cycles, got 0 expected 1", nm, budget);
    end
  endtask

  task automatic read_one(input string nm, input int exp);
    wait_until(nm, 0, 4000);
    chk(nm, int'($signed(pcm_data_o)), exp);
    pcm_read = 1'b1;
    @(negedge clk);
    pcm_read = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pcm_valid_o; i++) begin
      pcm_read = 1'b1;
      @(negedge clk);
    end
    pcm_read = 1'b0;
  endtask

  task automatic disable_check(input string nm);
    int hc;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk({nm, "_clk_low"}, int'(pdm_clk_o), 0);
    hc = 0;
    repeat (20) begin
      @(negedge clk);
      if (pdm_clk_o) hc++;
    end
    chk({nm, "_clk_stays_low"}, hc, 0);
  endtask

  initial begin : main
    int hc, lc, nr;
    repeat (3) @(negedge clk);
    chk("reset_pdm_clk", int'(pdm_clk_o), 0);
    chk("reset_valid", int'(pcm_valid_o), 0);
    chk("reset_data", int'(pcm_data_o), 0);
    chk("reset_full", int'(fifo_full_o), 0);
    chk("reset_overrun", int'(overrun_o), 0);
    #2 rst_n = 1'b1;

    // mic clock shape, then full-scale positive
    set_pat(4'b1111);
    @(negedge clk);
    enable = 1'b1;
    wait_until("clk_rise", 3, 50);
    hc = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pdm_clk_o) hc++; else break;
    end
    lc = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!pdm_clk_o) lc++; else break;
    end
    chk("clk_high_cycles", hc, DIV);
    chk("clk_low_cycles", lc, DIV);
    read_one("pos_fs_0", 32767);
    read_one("pos_fs_1", 32767);
    disable_check("dis1");
    drain();

    set_pat(4'b0000);
    @(negedge clk); enable = 1'b1;
    read_one("neg_fs_0", -32768);
    read_one("neg_fs_1", -32768);
    disable_check("dis2");
    drain();

    set_pat(4'b0101);   // 1,0,1,0
    @(negedge clk); enable = 1'b1;
    read_one("half_0", 0);
    read_one("half_1", 0);
    disable_check("dis3");
    drain();

    set_pat(4'b0111);   // 1,1,1,0
    @(negedge clk); enable = 1'b1;
    read_one("three_q_0", 16384);
    read_one("three_q_1", 16384);
    disable_check("dis4");
    drain();

    // overrun: fill without reading
    set_pat(4'b1111);
    @(negedge clk); enable = 1'b1;
    wait_until("fill_full", 1, 20000);
    chk("full_no_overrun_yet", int'(overrun_o), 0);
    wait_until("overrun_set", 2, 800);
    chk("overrun_flag", int'(overrun_o), 1);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("overrun_cleared", int'(overrun_o), 0);
    // pop lands on the edge of the next push (one decimation period after the drop)
    repeat (633) @(negedge clk);
    pcm_read = 1'b1;
    @(negedge clk);
    pcm_read = 1'b0;
    chk("pushpop_full_no_overrun", int'(overrun_o), 0);
    chk("pushpop_still_full", int'(fifo_full_o), 1);
    @(negedge clk); enable = 1'b0;
    nr = 0;
    for (int i = 0; i < 40 && pcm_valid_o; i++) begin
      chk("readback_value", int'($signed(pcm_data_o)), 32767);
      nr++;
      pcm_read = 1'b1;
      @(negedge clk);
      pcm_read = 1'b0;
    end
    chk("readback_count", nr, DEPTH);

    // disable mid-frame
    @(negedge clk); enable = 1'b1;
    wait_until("midframe_first", 0, 4000);
    repeat (30*2*DIV) @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("midframe_kept_valid", int'(pcm_valid_o), 1);
    chk("midframe_kept_data", int'($signed(pcm_data_o)), 32767);
    enable = 1'b1;
    read_one("midframe_old_head", 32767);
    read_one("midframe_new_first", 32767);
    disable_check("dis5");
    drain();

    // asynchronous reset while holding a sample
    @(negedge clk); enable = 1'b1;
    wait_until("pre_reset_sample", 0, 4000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(pcm_valid_o), 0);
    chk("async_rst_data", int'(pcm_data_o), 0);
    chk("async_rst_pdm_clk", int'(pdm_clk_o), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #(900000);
    nmis++;
    $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $fatal(1, "watchdog");
  end
endmodule
